// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the single-port memory arbiter: owner encodings and default hold limit.
package mem_port_arbiter_pkg;

  localparam logic OWNER_A      = 1'b0;
  localparam logic OWNER_B      = 1'b1;
  localparam int   MAX_HOLD_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Pure combinational grant decision for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin tie-break; default is fixed priority to port A.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_lock,
  input  logic              b_lock,
  input  logic              owner,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              a_gnt,
  output logic              b_gnt
);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && !b_req) begin
      a_gnt = 1'b1;
    end else if (b_req && !a_req) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      // Starvation guard outranks lock so a burst can never shut the other port out.
      if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
        if (owner == OWNER_A) b_gnt = 1'b1;
        else                  a_gnt = 1'b1;
      end else if (owner == OWNER_A && a_lock) begin
        a_gnt = 1'b1;
      end else if (owner == OWNER_B && b_lock) begin
        b_gnt = 1'b1;
      end else begin
`ifdef MEM_ARB_RR_EN
        if (owner == OWNER_A) b_gnt = 1'b1;
        else                  a_gnt = 1'b1;
`else
        a_gnt = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port front end for one single-port synchronous memory (1-cycle registered read).
// Tie-break policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 10,
  parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_wen,
  input  logic                 a_lock,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_din,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_dout,
  input  logic                 b_req,
  input  logic                 b_wen,
  input  logic                 b_lock,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_din,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_dout,
  output logic                 mem_cs,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_din,
  input  logic [WIDTH-1:0]     mem_dout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic              owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic              pick_a, pick_b;
  logic              other_req;

  mem_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_pick (
    .a_req    (a_req),
    .b_req    (b_req),
    .a_lock   (a_lock),
    .b_lock   (b_lock),
    .owner    (owner_q),
    .hold_cnt (hold_q),
    .a_gnt    (pick_a),
    .b_gnt    (pick_b)
  );

  // Grants are combinational, so gate them directly with reset to keep the memory quiet while held.
  assign a_gnt = pick_a & reset;
  assign b_gnt = pick_b & reset;

  always_comb begin
    owner_d   = owner_q;
    hold_d    = '0;
    other_req = 1'b0;
    if (a_gnt || b_gnt) begin
      owner_d   = a_gnt ? OWNER_A : OWNER_B;
      other_req = a_gnt ? b_req : a_req;
      if (owner_d == owner_q && other_req)
        hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
      else if (other_req)
        hold_d = HOLD_W'(1);
    end
  end

  always_comb begin
    mem_cs   = a_gnt | b_gnt;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (a_gnt) begin
      mem_wen  = a_wen;
      mem_addr = a_addr;
      mem_din  = a_din;
    end else if (b_gnt) begin
      mem_wen  = b_wen;
      mem_addr = b_addr;
      mem_din  = b_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWNER_B;
      hold_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      a_rvalid_q <= a_gnt & ~a_wen;
      b_rvalid_q <= b_gnt & ~b_wen;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_dout   = mem_dout;
  assign b_dout   = mem_dout;

endmodule
